arith_loop_monitor: RTL and testbench

- Downstream checking stage for the 13-bit triangular-sum loop counter (state i, j, k, n; i increments and j accumulates i while i<=n; k, n held).
- Samples the counter's registered outputs every cycle and runs a cycle-accurate shadow model of the same loop.
- Flags the first divergence and detects loop termination.
- Evaluates the safety property "not (i>n and 2n >= k+j+i)".
- Produces sticky status for the bench and the property-mining flow.

---
 rtl/arith_loop_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_arith_loop_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_loop_monitor.sv
// Checking stage for the triangular-sum loop counter: runs a shadow copy of the loop,
// flags the first divergence, detects termination and watches a safety property.
module arith_loop_monitor #(
  parameter int W       = 13,
  parameter int INIT_K  = 80,
  parameter int INIT_N  = 100,
  parameter int CW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  obs_i,
  input  logic [W-1:0]  obs_j,
  input  logic [W-1:0]  obs_k,
  input  logic [W-1:0]  obs_n,
  output logic          done,
  output logic [CW-1:0] done_cycle,
  output logic          mismatch,
  output logic [2:0]    fail_code,
  output logic [CW-1:0] fail_cycle,
  output logic          prop_fail,
  output logic [CW-1:0] cyc_cnt,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [W-1:0]  K_RST   = W'(INIT_K);
  localparam logic [W-1:0]  N_RST   = W'(INIT_N);
  localparam logic [CW-1:0] TO_CYC  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CYC_MAX = '1;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_TIMEOUT = 3'd5;
  localparam logic [2:0] FC_PROP    = 3'd6;

  state_t        state_q, state_d;
  logic [W-1:0]  si_q, si_d;
  logic [W-1:0]  sj_q, sj_d;
  logic [W-1:0]  sk_q, sk_d;
  logic [W-1:0]  sn_q, sn_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          done_q, done_d;
  logic [CW-1:0] done_cycle_q, done_cycle_d;
  logic          mismatch_q, mismatch_d;
  logic [2:0]    fail_code_q, fail_code_d;
  logic [CW-1:0] fail_cycle_q, fail_cycle_d;
  logic          prop_fail_q, prop_fail_d;

  // Field comparison: index 0..3 = i, j, k, n, which is also the priority order.
  logic [W-1:0] obs_f [4];
  logic [W-1:0] shd_f [4];
  logic [3:0]   field_ne;

  assign obs_f[0] = obs_i;
  assign obs_f[1] = obs_j;
  assign obs_f[2] = obs_k;
  assign obs_f[3] = obs_n;
  assign shd_f[0] = si_q;
  assign shd_f[1] = sj_q;
  assign shd_f[2] = sk_q;
  assign shd_f[3] = sn_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cmp
      assign field_ne[gi] = (obs_f[gi] != shd_f[gi]);
    end
  endgenerate

  logic [2:0] mm_code;
  always_comb begin
    mm_code = FC_NONE;
    if (field_ne[0])      mm_code = 3'd1;
    else if (field_ne[1]) mm_code = 3'd2;
    else if (field_ne[2]) mm_code = 3'd3;
    else if (field_ne[3]) mm_code = 3'd4;
  end

  // Property sum is widened by two bits so that neither 2n nor k+j+i can wrap.
  logic [W+1:0] prop_lhs;
  logic [W+1:0] prop_rhs;
  logic         term_seen;
  logic         prop_viol;
  logic         timeout_hit;

  assign prop_lhs    = {1'b0, obs_n, 1'b0};
  assign prop_rhs    = {2'b00, obs_k} + {2'b00, obs_j} + {2'b00, obs_i};
  assign term_seen   = (obs_i > obs_n);
  assign prop_viol   = term_seen && (prop_lhs >= prop_rhs);
  assign timeout_hit = (cyc_q == TO_CYC);

  always_comb begin
    state_d      = state_q;
    si_d         = si_q;
    sj_d         = sj_q;
    sk_d         = sk_q;
    sn_d         = sn_q;
    cyc_d        = cyc_q;
    done_d       = done_q;
    done_cycle_d = done_cycle_q;
    mismatch_d   = mismatch_q;
    fail_code_d  = fail_code_q;
    fail_cycle_d = fail_cycle_q;
    prop_fail_d  = prop_fail_q;

    if (cyc_q != CYC_MAX) begin
      cyc_d = cyc_q + 1'b1;
    end

    // Shadow advances only while running; j accumulates the pre-increment i.
    if (state_q == ST_RUN && si_q <= sn_q) begin
      si_d = si_q + 1'b1;
      sj_d = sj_q + si_q;
    end

    if (prop_viol) begin
      prop_fail_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (mm_code != FC_NONE) begin
          mismatch_d   = 1'b1;
          fail_code_d  = mm_code;
          fail_cycle_d = cyc_q;
          state_d      = ST_FAIL;
        end else begin
          if (term_seen) begin
            done_d       = 1'b1;
            done_cycle_d = cyc_q;
            state_d      = ST_DONE;
          end
          if (prop_viol) begin
            fail_code_d  = FC_PROP;
            fail_cycle_d = cyc_q;
            state_d      = ST_FAIL;
          end else if (!term_seen && timeout_hit) begin
            fail_code_d  = FC_TIMEOUT;
            fail_cycle_d = cyc_q;
            state_d      = ST_FAIL;
          end
        end
      end
      ST_DONE: begin
        if (mm_code != FC_NONE) begin
          mismatch_d   = 1'b1;
          fail_code_d  = mm_code;
          fail_cycle_d = cyc_q;
          state_d      = ST_FAIL;
        end else if (prop_viol) begin
          fail_code_d  = FC_PROP;
          fail_cycle_d = cyc_q;
          state_d      = ST_FAIL;
        end
      end
      default: begin
        state_d = ST_FAIL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      si_q         <= '0;
      sj_q         <= '0;
      sk_q         <= K_RST;
      sn_q         <= N_RST;
      cyc_q        <= '0;
      done_q       <= 1'b0;
      done_cycle_q <= '0;
      mismatch_q   <= 1'b0;
      fail_code_q  <= FC_NONE;
      fail_cycle_q <= '0;
      prop_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      si_q         <= si_d;
      sj_q         <= sj_d;
      sk_q         <= sk_d;
      sn_q         <= sn_d;
      cyc_q        <= cyc_d;
      done_q       <= done_d;
      done_cycle_q <= done_cycle_d;
      mismatch_q   <= mismatch_d;
      fail_code_q  <= fail_code_d;
      fail_cycle_q <= fail_cycle_d;
      prop_fail_q  <= prop_fail_d;
    end
  end

  assign done       = done_q;
  assign done_cycle = done_cycle_q;
  assign mismatch   = mismatch_q;
  assign fail_code  = fail_code_q;
  assign fail_cycle = fail_cycle_q;
  assign prop_fail  = prop_fail_q;
  assign cyc_cnt    = cyc_q;
  assign state      = state_q;

endmodule

// File: tb/tb_arith_loop_monitor.sv
// Scoreboard bench for arith_loop_monitor: a behavioural loop counter feeds the monitor,
// with per-cycle overrides to inject faults; expected status is queued per edge.
module tb_arith_loop_monitor;

  logic        clk;
  logic        rst;
  logic [12:0] obs_i, obs_j, obs_k, obs_n;

  logic        done, done_t5, done_t1;
  logic [15:0] done_cycle, done_cycle_t5, done_cycle_t1;
  logic        mismatch, mismatch_t5, mismatch_t1;
  logic [2:0]  fail_code, fail_code_t5, fail_code_t1;
  logic [15:0] fail_cycle, fail_cycle_t5, fail_cycle_t1;
  logic        prop_fail, prop_fail_t5, prop_fail_t1;
  logic [15:0] cyc_cnt, cyc_cnt_t5, cyc_cnt_t1;
  logic [1:0]  state, state_t5, state_t1;

  arith_loop_monitor u_dut (
    .clk(clk), .rst(rst), .obs_i(obs_i), .obs_j(obs_j), .obs_k(obs_k), .obs_n(obs_n),
    .done(done), .done_cycle(done_cycle), .mismatch(mismatch), .fail_code(fail_code),
    .fail_cycle(fail_cycle), .prop_fail(prop_fail), .cyc_cnt(cyc_cnt), .state(state)
  );

  arith_loop_monitor #(.TIMEOUT(50)) u_to50 (
    .clk(clk), .rst(rst), .obs_i(obs_i), .obs_j(obs_j), .obs_k(obs_k), .obs_n(obs_n),
    .done(done_t5), .done_cycle(done_cycle_t5), .mismatch(mismatch_t5), .fail_code(fail_code_t5),
    .fail_cycle(fail_cycle_t5), .prop_fail(prop_fail_t5), .cyc_cnt(cyc_cnt_t5), .state(state_t5)
  );

  arith_loop_monitor #(.TIMEOUT(101)) u_to101 (
    .clk(clk), .rst(rst), .obs_i(obs_i), .obs_j(obs_j), .obs_k(obs_k), .obs_n(obs_n),
    .done(done_t1), .done_cycle(done_cycle_t1), .mismatch(mismatch_t1), .fail_code(fail_code_t1),
    .fail_cycle(fail_cycle_t1), .prop_fail(prop_fail_t1), .cyc_cnt(cyc_cnt_t1), .state(state_t1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural loop counter (reset i=0, j=0, k=80, n=100).
  logic [12:0] c_i, c_j;

  // Per-cycle override controls.
  bit          f_i_en, f_j_en, f_k_en, f_n_en;
  logic [12:0] f_i, f_j, f_k, f_n;

  // Reference model of the monitor (default TIMEOUT).
  localparam int TO = 1023;
  logic [12:0] m_si, m_sj;
  logic [1:0]  m_st;
  logic        m_done, m_mm, m_pf;
  logic [2:0]  m_fc;
  logic [15:0] m_dcyc, m_fcyc, m_cyc;

  typedef struct {
    logic [1:0]  st;
    logic        done;
    logic        mm;
    logic        pf;
    logic [2:0]  fc;
    logic [15:0] dcyc;
    logic [15:0] fcyc;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic model_fail(input logic [2:0] code, input logic [15:0] t);
    m_fc   = code;
    m_fcyc = t;
    m_st   = 2'd2;
  endtask

  task automatic model_edge(input logic r, input logic [12:0] oi, oj, ok, on);
    logic [2:0]  code;
    logic [15:0] t;
    bit          term, prop, was_run;
    if (r) begin
      m_si = 0; m_sj = 0; m_st = 0; m_done = 0; m_mm = 0; m_pf = 0;
      m_fc = 0; m_dcyc = 0; m_fcyc = 0; m_cyc = 0;
    end else begin
      t = m_cyc;
      if (oi != m_si)      code = 3'd1;
      else if (oj != m_sj) code = 3'd2;
      else if (ok != 80)   code = 3'd3;
      else if (on != 100)  code = 3'd4;
      else                 code = 3'd0;
      term = (oi > on);
      prop = term && (2 * int'(on) >= int'(ok) + int'(oj) + int'(oi));
      if (prop) m_pf = 1'b1;
      was_run = (m_st == 2'd0);
      if (m_st == 2'd0) begin
        if (code != 0) begin
          m_mm = 1'b1;
          model_fail(code, t);
        end else begin
          if (term) begin
            m_done = 1'b1; m_dcyc = t; m_st = 2'd1;
          end
          if (prop) model_fail(3'd6, t);
          else if (!term && int'(t) == TO) model_fail(3'd5, t);
        end
      end else if (m_st == 2'd1) begin
        if (code != 0) begin
          m_mm = 1'b1;
          model_fail(code, t);
        end else if (prop) begin
          model_fail(3'd6, t);
        end
      end
      if (was_run && m_si <= 13'd100) begin
        m_sj = m_sj + m_si;
        m_si = m_si + 13'd1;
      end
      if (m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
    end
  endtask

  task automatic step(input logic r);
    logic [12:0] oi, oj, ok, on;
    exp_t e;
    @(negedge clk);
    oi = f_i_en ? f_i : c_i;
    oj = f_j_en ? f_j : c_j;
    ok = f_k_en ? f_k : 13'd80;
    on = f_n_en ? f_n : 13'd100;
    rst = r; obs_i = oi; obs_j = oj; obs_k = ok; obs_n = on;
    model_edge(r, oi, oj, ok, on);
    e = '{m_st, m_done, m_mm, m_pf, m_fc, m_dcyc, m_fcyc, m_cyc};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      c_i = 0; c_j = 0;
    end else if (c_i <= 13'd100) begin
      c_j = c_j + c_i;
      c_i = c_i + 13'd1;
    end
    e = sb_q.pop_front();
    chk("state", 32'(state), 32'(e.st));
    chk("done", 32'(done), 32'(e.done));
    chk("mismatch", 32'(mismatch), 32'(e.mm));
    chk("prop_fail", 32'(prop_fail), 32'(e.pf));
    chk("fail_code", 32'(fail_code), 32'(e.fc));
    chk("done_cycle", 32'(done_cycle), 32'(e.dcyc));
    chk("fail_cycle", 32'(fail_cycle), 32'(e.fcyc));
    chk("cyc_cnt", 32'(cyc_cnt), 32'(e.cyc));
    $display("step rst=%0d i=%0d j=%0d k=%0d n=%0d -> st=%0d fc=%0d cyc=%0d",
             r, oi, oj, ok, on, state, fail_code, cyc_cnt);
  endtask

  task automatic clear_forces();
    f_i_en = 0; f_j_en = 0; f_k_en = 0; f_n_en = 0;
  endtask

  task automatic do_reset();
    clear_forces();
    step(1'b1);
    step(1'b1);
  endtask

  initial begin
    rst = 1'b1; obs_i = 0; obs_j = 0; obs_k = 80; obs_n = 100;
    c_i = 0; c_j = 0;
    f_i = 0; f_j = 0; f_k = 0; f_n = 0;
    clear_forces();

    // Reset state
    do_reset();
    chk("rst_state", 32'(state), 0);
    chk("rst_cyc", 32'(cyc_cnt), 0);
    chk("rst_done", 32'(done), 0);

    // Nominal run, 120 cycles
    for (int t = 0; t < 120; t++) step(1'b0);
    chk("nom_done", 32'(done), 1);
    chk("nom_done_cycle", 32'(done_cycle), 101);
    chk("nom_mismatch", 32'(mismatch), 0);
    chk("nom_prop", 32'(prop_fail), 0);
    chk("nom_state", 32'(state), 1);
    chk("nom_cyc", 32'(cyc_cnt), 120);
    chk("to50_code", 32'(fail_code_t5), 5);
    chk("to50_cycle", 32'(fail_cycle_t5), 50);
    chk("to50_done", 32'(done_t5), 0);
    chk("to50_state", 32'(state_t5), 2);
    chk("to101_state", 32'(state_t1), 1);
    chk("to101_done_cycle", 32'(done_cycle_t1), 101);
    chk("to101_code", 32'(fail_code_t1), 0);

    // j off by one at t=50 only
    do_reset();
    for (int t = 0; t < 70; t++) begin
      f_j_en = (t == 50);
      f_j = c_j + 13'd1;
      step(1'b0);
    end
    chk("jerr_code", 32'(fail_code), 2);
    chk("jerr_cycle", 32'(fail_cycle), 50);
    chk("jerr_state", 32'(state), 2);
    chk("jerr_mm", 32'(mismatch), 1);

    // i frozen at 20 from t=20; later a property violation while already failed
    do_reset();
    for (int t = 0; t < 45; t++) begin
      f_i_en = (t >= 20);
      f_i = (t == 40) ? 13'd101 : 13'd20;
      f_j_en = (t == 40); f_j = 0;
      f_k_en = (t == 40); f_k = 0;
      step(1'b0);
    end
    chk("ifrz_code", 32'(fail_code), 1);
    chk("ifrz_cycle", 32'(fail_cycle), 21);
    chk("ifrz_prop", 32'(prop_fail), 1);

    // i and k wrong together: i has priority
    do_reset();
    for (int t = 0; t < 35; t++) begin
      f_i_en = (t == 30); f_i = c_i + 13'd5;
      f_k_en = (t == 30); f_k = 13'd7;
      step(1'b0);
    end
    chk("prio_code", 32'(fail_code), 1);
    chk("prio_cycle", 32'(fail_cycle), 30);

    // After done, property values plus j mismatch: mismatch code wins, prop_fail sets
    do_reset();
    for (int t = 0; t < 110; t++) begin
      f_i_en = (t == 105); f_i = 13'd101;
      f_j_en = (t == 105); f_j = 0;
      f_k_en = (t == 105); f_k = 0;
      f_n_en = (t == 105); f_n = 13'd100;
      step(1'b0);
    end
    chk("pdone_prop", 32'(prop_fail), 1);
    chk("pdone_code", 32'(fail_code), 2);
    chk("pdone_cycle", 32'(fail_cycle), 105);
    chk("pdone_done", 32'(done), 1);

    // Failure, then mid-run reset, then a clean run measured from the new release
    do_reset();
    for (int t = 0; t < 60; t++) begin
      f_j_en = (t == 30); f_j = c_j + 13'd3;
      step(1'b0);
    end
    clear_forces();
    step(1'b1);
    chk("mrst_state", 32'(state), 0);
    chk("mrst_code", 32'(fail_code), 0);
    chk("mrst_mm", 32'(mismatch), 0);
    for (int t = 0; t < 120; t++) step(1'b0);
    chk("mrst_done_cycle", 32'(done_cycle), 101);
    chk("mrst_final_state", 32'(state), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
